// File: rtl/ripemd160_chain_final.sv
// RIPEMD-160 finalisation and chaining stage.
// Combines the left/right line results of each 512-bit block with the chaining
// value H, feeds H back to the round cores, and on the last block of a message
// presents the digest on a valid/ready output.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never waits on ready; while valid is high and ready is low
// the producer holds its payload stable.
module ripemd160_chain_final #(
  parameter int PIPE_STAGES   = 2,
  parameter bit BYTE_SWAP_OUT = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [159:0]     in_left,
  input  logic [159:0]     in_right,
  output logic [159:0]     chain_h,
  output logic             chain_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [159:0]     out_digest,
  output logic [CNT_W-1:0] out_nblocks,
  output logic             err_seq,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BUSY, S_HOLD} state_t;

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [1:0]   BUSY_LAST = 2'(PIPE_STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Left/right cross terms, word order h0'..h4':
  // {C+D', D+E', E+A', A+B', B+C'}
  function automatic logic [159:0] cross_sum(input logic [159:0] l, input logic [159:0] r);
    cross_sum = {l[95:64]   + r[63:32],
                 l[63:32]   + r[31:0],
                 l[31:0]    + r[159:128],
                 l[159:128] + r[127:96],
                 l[127:96]  + r[95:64]};
  endfunction

  // Word-wise modulo-2^32 addition of five packed words.
  function automatic logic [159:0] add_words(input logic [159:0] a, input logic [159:0] b);
    add_words = {a[159:128] + b[159:128],
                 a[127:96]  + b[127:96],
                 a[95:64]   + b[95:64],
                 a[63:32]   + b[63:32],
                 a[31:0]    + b[31:0]};
  endfunction

  // Reverse the bytes inside each 32-bit word, word positions unchanged.
  function automatic logic [159:0] swap_bytes(input logic [159:0] x);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        swap_bytes[w*32 + b*8 +: 8] = x[w*32 + (3-b)*8 +: 8];
      end
    end
  endfunction

  state_t             state_q, state_d;
  logic [159:0]       h_q, h_d;
  logic [159:0]       l_q, l_d;
  logic [159:0]       r_q, r_d;
  logic [159:0]       sum_q, sum_d;
  logic [159:0]       dig_q, dig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  // Adder pipeline: H is rotated so h1 lines up with the h0' terms.
  if (PIPE_STAGES == 1) begin : g_pipe1
    // Single registered three-operand sum.
    always_comb sum_d = add_words({h_q[127:0], h_q[159:128]}, cross_sum(l_q, r_q));
  end else begin : g_pipe2
    logic [159:0] p_q;
    // Register the left+right partial sums first.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) p_q <= '0;
      else        p_q <= cross_sum(l_q, r_q);
    end
    always_comb sum_d = add_words({h_q[127:0], h_q[159:128]}, p_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= IV;
      l_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      nblk_q  <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      l_q     <= l_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      nblk_q  <= nblk_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state, sequencing checks and handshake outputs.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    l_d         = l_q;
    r_d         = r_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    nblk_d      = nblk_q;
    bcnt_d      = bcnt_q;
    last_d      = last_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    chain_valid = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_first) begin
            h_d     = IV;
            cnt_d   = CNT_ONE;
            l_d     = in_left;
            r_d     = in_right;
            last_d  = in_last;
            bcnt_d  = '0;
            state_d = S_BUSY;
          end else begin
            // Continuation block with no open message: drop it.
            err_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        in_ready    = 1'b1;
        chain_valid = 1'b1;
        if (in_valid) begin
          l_d     = in_left;
          r_d     = in_right;
          last_d  = in_last;
          bcnt_d  = '0;
          state_d = S_BUSY;
          if (in_first) begin
            // Unterminated message abandoned; restart from IV.
            err_d = 1'b1;
            h_d   = IV;
            cnt_d = CNT_ONE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_BUSY: begin
        if (bcnt_q == BUSY_LAST) begin
          h_d = sum_q;
          if (last_q) begin
            dig_d   = BYTE_SWAP_OUT ? swap_bytes(sum_q) : sum_q;
            nblk_d  = cnt_q;
            state_d = S_HOLD;
          end else begin
            state_d = S_ACTIVE;
          end
        end else begin
          bcnt_d = bcnt_q + 2'd1;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          h_d     = IV;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign chain_h     = h_q;
  assign out_digest  = dig_q;
  assign out_nblocks = nblk_q;
  assign err_seq     = err_q;
  assign dbg_state   = state_q;

endmodule
